strobe_spi_master: RTL and testbench
====================================

Name: strobe_spi_master

Overview:
- Serial command master paced by the 2 MHz strobe from the clock-divider block. One strobe is one SCLK half-period, so SCLK runs at 1 MHz.
- Takes a command word over a valid/ready handshake and drives it MSB-first, SPI mode 0 (CPOL=0, CPHA=0), to the front-end ASIC.
- Captures the ASIC's MISO word during the same frame and returns it with a one-cycle valid pulse.
- Sits between the register/config sequencer and the ASIC pads.

Parameters:
- WORD_W, 16, bits per frame (legal range 2..32).
- GAP_TICKS, 2, minimum number of strobes with CSB high between frames (legal range 1..15).

Ports:
- clk  input  1  system clock (20 MHz).
- rstb  input  1  reset, asynchronous and active-low.
- stb  input  1  single-cycle pacing strobe, one pulse every N clk cycles.
- cmd_data  input  WORD_W  command word to transmit.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- rsp_data  output  WORD_W  word captured from MISO in the last frame.
- rsp_valid  output  1  one-cycle pulse; rsp_data is valid in that cycle.
- busy  output  1  high from accept until the GAP state ends.
- csb  output  1  chip select, active-low.
- sclk  output  1  serial clock.
- mosi  output  1  serial data out.
- miso  input  1  serial data in.

Behaviour:
- All outputs are registered.
- Reset values: csb=1, sclk=0, mosi=0, cmd_ready=0, busy=0, rsp_valid=0, rsp_data=0, state=GAP with gap counter=GAP_TICKS. This gives a guaranteed CSB-high time after reset.
- Reset mid-frame aborts immediately and asynchronously: csb goes high and sclk goes low with no glitch to the reset values. No rsp_valid is generated for the aborted frame.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE: cmd_ready=1. Strobes are ignored. A command is accepted when cmd_valid and cmd_ready are both high on a clk edge.
    - On accept: latch cmd_data into the tx shifter, clear the rx shifter, drive csb=0 and mosi=cmd_data[WORD_W-1] on the next cycle.
    - Also on accept: cmd_ready=0, busy=1, go to SETUP.
  - SETUP: wait for one strobe. A strobe in the same cycle as the accept does not count. On the first later strobe, go to SHIFT with tick counter=0.
  - SHIFT: each strobe advances the tick counter from 0 to 2*WORD_W-1.
    - Even tick: sclk goes to 1 (rising edge; the ASIC samples mosi).
    - Odd tick: sample miso into the rx LSB, shifting left, while sclk is still high. In the same cycle, sclk goes to 0 and mosi takes the next tx bit.
    - After the final odd tick (2*WORD_W-1): mosi=0, go to HOLD.
  - HOLD: sclk stays 0. On the next strobe: csb=1, rsp_data=rx shifter, rsp_valid=1 for exactly one clk, load the gap counter with GAP_TICKS, go to GAP.
  - GAP: decrement the gap counter on each strobe. When it reaches 0, busy=0 and go to IDLE; cmd_ready rises in the same cycle.
- No strobes means a frozen frame: every output holds its value indefinitely. The block has no timeout.
- Strobe budget per frame, from SETUP entry to IDLE: 1 + 2*WORD_W + 1 + GAP_TICKS.
- Timing at 20 MHz with a divide-by-10 strobe:
  - sclk high and low phases are each exactly 10 clk cycles.
  - mosi setup before a rising sclk edge is 10 clk cycles.
  - csb-low to first sclk rise is at least 10 clk cycles.
- cmd_data is sampled only at accept; later changes are ignored. While busy, cmd_valid is ignored, and cmd_ready stays 0 until GAP ends.
- rsp_data holds its value until the next frame's HOLD-exit strobe.
- The tick counter is log2(2*WORD_W) bits and never wraps inside SHIFT.

Decomposition:
- Shared package spi_pkg:
  - state enum (IDLE, SETUP, SHIFT, HOLD, GAP) in 3-bit encoding;
  - default WORD_W and GAP_TICKS constants;
  - a function giving the tick-counter width.
- One sub-module, spi_shift_pair: the tx and rx shift registers with load, shift_tx, and sample_rx enables. It carries no pacing logic.
- The strobe source is instantiated outside this block and is not embedded.

Test Plan:
- Basic frame: WORD_W=16, cmd_data=16'hA5C3 held with cmd_valid, MISO model returns 16'h3C5A on falling sclk edges.
  - Required: mosi bits on rising sclk edges equal A5C3 MSB-first, in exactly 16 rising edges.
  - Required: rsp_data=16'h3C5A with a single-cycle rsp_valid, and csb low for 34 strobes.
- Back-to-back commands: cmd_valid held high with two words, 16'h0001 then 16'hFFFF.
  - Required: second accept occurs exactly GAP_TICKS=2 strobes after csb rises, csb-high gap is ≥20 clk cycles, and both responses are correct.
- Strobe coincident with accept, and strobe in IDLE: strobe in IDLE leaves no state change. Strobe in the accept cycle is not counted: first sclk rise occurs on the 2nd strobe after accept, not the 1st.
- Strobe stall: stop strobes after 5 rising edges for 200 clk cycles. Required: sclk, csb, and mosi stay constant, and the frame completes correctly once strobes resume.
- Reset mid-SHIFT: drive rstb low after bit 7. Required: in the same cycle csb=1 and sclk=0, no rsp_valid, cmd_ready=0. After release, cmd_ready rises only after 2 strobes.
- Parameter sweep: WORD_W=2 and WORD_W=32 with GAP_TICKS=1. Required: correct bit counts and loopback data (mosi tied to miso gives rsp_data == cmd_data).

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and defaults for the strobe-paced SPI command master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int WORD_W_DEF    = 16;
  localparam int GAP_TICKS_DEF = 2;
  localparam int GAP_CW        = 4;

  function automatic int tick_w(input int word_w);
    return $clog2(2 * word_w);
  endfunction

endpackage

// File: rtl/spi_shift_pair.sv
// TX/RX shift registers for one SPI frame; pacing lives in the parent.
module spi_shift_pair #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              load,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              shift_tx,
  input  logic              sample_rx,
  input  logic              miso,
  output logic              tx_msb,
  output logic [WORD_W-1:0] rx_word
);

  logic [WORD_W-1:0] tx_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tx_q    <= '0;
      rx_word <= '0;
    end else if (load) begin
      tx_q    <= ld_data;
      rx_word <= '0;
    end else begin
      if (shift_tx)
        tx_q <= {tx_q[WORD_W-2:0], 1'b0};
      if (sample_rx)
        rx_word <= {rx_word[WORD_W-2:0], miso};
    end
  end

  assign tx_msb = tx_q[WORD_W-1];

endmodule

// File: rtl/strobe_spi_master.sv
// Strobe-paced SPI mode-0 command master: one strobe per SCLK half-period.
module strobe_spi_master
  import spi_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int GAP_TICKS = GAP_TICKS_DEF
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              stb,
  input  logic [WORD_W-1:0] cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_valid,
  output logic              busy,
  output logic              csb,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int TW = tick_w(WORD_W);
  localparam logic [TW-1:0] LAST_TICK = TW'(2 * WORD_W - 1);
  localparam logic [GAP_CW-1:0] GAP_LD = GAP_CW'(GAP_TICKS);

  state_t state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [GAP_CW-1:0] gap_q, gap_d;
  logic csb_d, sclk_d, mosi_d;
  logic ready_d, busy_d, rvalid_d;
  logic [WORD_W-1:0] rdata_d;
  logic load, shift_tx, sample_rx, tx_msb;
  logic [WORD_W-1:0] rx_word;

  spi_shift_pair #(.WORD_W(WORD_W)) u_sr (
    .clk      (clk),
    .rstb     (rstb),
    .load     (load),
    .ld_data  (cmd_data),
    .shift_tx (shift_tx),
    .sample_rx(sample_rx),
    .miso     (miso),
    .tx_msb   (tx_msb),
    .rx_word  (rx_word)
  );

  // Reset lands in GAP so CSB is guaranteed high for a full gap.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= GAP;
      tick_q    <= '0;
      gap_q     <= GAP_LD;
      csb       <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      gap_q     <= gap_d;
      csb       <= csb_d;
      sclk      <= sclk_d;
      mosi      <= mosi_d;
      cmd_ready <= ready_d;
      busy      <= busy_d;
      rsp_valid <= rvalid_d;
      rsp_data  <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    gap_d     = gap_q;
    csb_d     = csb;
    sclk_d    = sclk;
    mosi_d    = mosi;
    ready_d   = cmd_ready;
    busy_d    = busy;
    rvalid_d  = 1'b0;
    rdata_d   = rsp_data;
    load      = 1'b0;
    shift_tx  = 1'b0;
    sample_rx = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          load    = 1'b1;
          csb_d   = 1'b0;
          mosi_d  = cmd_data[WORD_W-1];
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (stb) begin
          tick_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (stb) begin
          tick_d = tick_q + 1'b1;
          // TX shifts on the rise so its MSB is the next bit at the fall.
          if (!tick_q[0]) begin
            sclk_d   = 1'b1;
            shift_tx = 1'b1;
          end else begin
            sample_rx = 1'b1;
            sclk_d    = 1'b0;
            mosi_d    = tx_msb;
            if (tick_q == LAST_TICK) begin
              mosi_d  = 1'b0;
              tick_d  = '0;
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (stb) begin
          csb_d    = 1'b1;
          rdata_d  = rx_word;
          rvalid_d = 1'b1;
          gap_d    = GAP_LD;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (stb) begin
          gap_d = gap_q - 1'b1;
          if (gap_q == GAP_CW'(1)) begin
            busy_d  = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = GAP;
    endcase
  end

endmodule

// File: tb/tb_strobe_spi_master.sv
// Bench for strobe_spi_master: 16-bit frames against an ASIC model, 2/32-bit loopback.
module tb_strobe_spi_master;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic stb_en = 1'b1;
  int div = 0;
  logic stb;

  always #5 clk = ~clk;
  always @(posedge clk) div <= (div == 9) ? 0 : div + 1;
  assign stb = stb_en && (div == 9);

  logic [15:0] cd16 = '0;
  logic cv16 = 1'b0;
  logic rdy16, rv16, busy16, csb16, sclk16, mosi16, miso16;
  logic [15:0] rd16;

  logic [1:0] cd2 = '0;
  logic cv2 = 1'b0;
  logic rdy2, rv2, busy2, csb2, sclk2, mosi2;
  logic [1:0] rd2;

  logic [31:0] cd32 = '0;
  logic cv32 = 1'b0;
  logic rdy32, rv32, busy32, csb32, sclk32, mosi32;
  logic [31:0] rd32;

  strobe_spi_master #(.WORD_W(16), .GAP_TICKS(2)) u16 (
    .clk(clk), .rstb(rstb), .stb(stb),
    .cmd_data(cd16), .cmd_valid(cv16), .cmd_ready(rdy16),
    .rsp_data(rd16), .rsp_valid(rv16), .busy(busy16),
    .csb(csb16), .sclk(sclk16), .mosi(mosi16), .miso(miso16)
  );

  strobe_spi_master #(.WORD_W(2), .GAP_TICKS(1)) u2 (
    .clk(clk), .rstb(rstb), .stb(stb),
    .cmd_data(cd2), .cmd_valid(cv2), .cmd_ready(rdy2),
    .rsp_data(rd2), .rsp_valid(rv2), .busy(busy2),
    .csb(csb2), .sclk(sclk2), .mosi(mosi2), .miso(mosi2)
  );

  strobe_spi_master #(.WORD_W(32), .GAP_TICKS(1)) u32 (
    .clk(clk), .rstb(rstb), .stb(stb),
    .cmd_data(cd32), .cmd_valid(cv32), .cmd_ready(rdy32),
    .rsp_data(rd32), .rsp_valid(rv32), .busy(busy32),
    .csb(csb32), .sclk(sclk32), .mosi(mosi32), .miso(mosi32)
  );

  // ASIC model: presents its word MSB-first, advancing after each SCLK fall.
  logic [15:0] asic_word = '0;
  int afall = 0;
  logic asp = 1'b0;
  int hi_run = 0;
  int last_hi = 0;

  function automatic logic pick(input logic [15:0] w, input int i);
    logic [15:0] t;
    t = w << i;
    return t[15];
  endfunction

  assign miso16 = pick(asic_word, afall);

  always @(negedge clk) begin
    if (csb16) afall <= 0;
    else if (asp && !sclk16) afall <= afall + 1;
    asp <= sclk16;
    if (csb16) hi_run <= hi_run + 1;
    else begin
      if (hi_run > 0) last_hi <= hi_run;
      hi_run <= 0;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready_count(output int cnt, output bit rvseen);
    int cyc;
    logic sb;
    cyc = 0;
    cnt = 0;
    rvseen = 1'b0;
    sb = stb;
    while (!rdy16 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (sb) cnt++;
      if (rv16) rvseen = 1'b1;
      sb = stb;
    end
  endtask

  task automatic frame16(input logic [15:0] cmd, input logic [15:0] mw,
                         input bit coincide, input bit stall,
                         input int abort_at);
    int cyc = 0, nrise = 0, stb_acc = 0, first_rise = -1;
    int lo = 0, hi = 0, nv = 0, cnt = 0;
    logic [15:0] got = '0, rsp = '0;
    logic [2:0] snap;
    logic sp, cp, sb;
    bit done = 0, stalled = 0, chg = 0, rvseen = 0;
    asic_word = mw;
    while (!rdy16 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_wait", rdy16, 1'b1);
    if (coincide) begin
      cyc = 0;
      while (!stb && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      chk("coincide_stb", stb, 1'b1);
    end
    cd16 = cmd;
    cv16 = 1'b1;
    @(negedge clk);
    cv16 = 1'b0;
    cd16 = 16'($urandom);
    chk("accept", {csb16, mosi16, busy16, rdy16},
        {1'b0, cmd[15], 1'b1, 1'b0});
    sp = sclk16;
    cp = csb16;
    sb = stb;
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (sb) begin
        stb_acc++;
        if (!cp) lo++;
        else hi++;
      end
      if (sclk16 && !sp) begin
        nrise++;
        got = {got[14:0], mosi16};
        if (nrise == 1) first_rise = stb_acc;
        if (stall && nrise == 5 && !stalled) begin
          stalled = 1'b1;
          stb_en = 1'b0;
          snap = {sclk16, csb16, mosi16};
          repeat (200) begin
            @(negedge clk);
            if ({sclk16, csb16, mosi16} !== snap) chg = 1'b1;
          end
          chk("stall_hold", chg, 1'b0);
          stb_en = 1'b1;
        end
        if (abort_at != 0 && nrise == abort_at) begin
          rstb = 1'b0;
          #1;
          chk("abort_out", {csb16, sclk16, rdy16, rv16, busy16}, 5'b10000);
          repeat (3) @(negedge clk);
          rstb = 1'b1;
          wait_ready_count(cnt, rvseen);
          chk("abort_gap_stb", cnt, 2);
          chk("abort_no_rsp", rvseen, 1'b0);
          return;
        end
      end
      if (rv16) begin
        nv++;
        rsp = rd16;
      end
      if (rdy16) done = 1'b1;
      sp = sclk16;
      cp = csb16;
      sb = stb;
    end
    chk("frame_done", done, 1'b1);
    chk("rise_cnt", nrise, 16);
    chk("mosi_word", got, cmd);
    chk("rsp_data", rsp, mw);
    chk("rsp_pulse", nv, 1);
    chk("csb_low_stb", lo, 2 * 16 + 2);
    chk("gap_stb", hi, 2);
    chk("first_rise_stb", first_rise, 2);
    chk("rsp_hold", rd16, mw);
  endtask

  task automatic sweep(input bit big, input logic [31:0] cmd);
    int w, cyc = 0, nrise = 0, lo = 0, hi = 0, nv = 0;
    logic [31:0] m, got = '0, rsp = '0, rd;
    logic sp, cp, sb, rdy, sc, cs, mo, rv;
    bit done = 0;
    w = big ? 32 : 2;
    m = big ? 32'hFFFF_FFFF : 32'h3;
    rdy = big ? rdy32 : rdy2;
    while (!rdy && cyc < 500) begin
      @(negedge clk);
      cyc++;
      rdy = big ? rdy32 : rdy2;
    end
    chk("sw_ready", rdy, 1'b1);
    cd2 = cmd[1:0];
    cd32 = cmd;
    if (big) cv32 = 1'b1;
    else cv2 = 1'b1;
    @(negedge clk);
    cv2 = 1'b0;
    cv32 = 1'b0;
    sp = big ? sclk32 : sclk2;
    cp = big ? csb32 : csb2;
    sb = stb;
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      sc = big ? sclk32 : sclk2;
      cs = big ? csb32 : csb2;
      mo = big ? mosi32 : mosi2;
      rv = big ? rv32 : rv2;
      rd = big ? rd32 : {30'b0, rd2};
      rdy = big ? rdy32 : rdy2;
      if (sb) begin
        if (!cp) lo++;
        else hi++;
      end
      if (sc && !sp) begin
        nrise++;
        got = {got[30:0], mo};
      end
      if (rv) begin
        nv++;
        rsp = rd;
      end
      if (rdy) done = 1'b1;
      sp = sc;
      cp = cs;
      sb = stb;
    end
    chk("sw_done", done, 1'b1);
    chk("sw_rise_cnt", nrise, w);
    chk("sw_mosi_word", got, cmd & m);
    chk("sw_loopback", rsp, cmd & m);
    chk("sw_rsp_pulse", nv, 1);
    chk("sw_csb_low_stb", lo, 2 * w + 2);
    chk("sw_gap_stb", hi, 1);
  endtask

  initial begin
    int cnt;
    bit rvseen;
    logic [25:0] idle_snap;
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {csb16, sclk16, mosi16, rdy16, busy16, rv16}, 6'b100000);
    chk("reset_rsp", rd16, 16'h0);
    rstb = 1'b1;
    wait_ready_count(cnt, rvseen);
    chk("reset_gap_stb", cnt, 2);

    idle_snap = {rdy16, csb16, sclk16, mosi16, busy16, rv16, 4'h0, rd16};
    repeat (25) @(negedge clk);
    chk("idle_stb", {rdy16, csb16, sclk16, mosi16, busy16, rv16, 4'h0, rd16},
        idle_snap);

    frame16(16'hA5C3, 16'h3C5A, 1'b0, 1'b0, 0);

    frame16(16'h0001, 16'($urandom), 1'b0, 1'b0, 0);
    frame16(16'hFFFF, 16'($urandom), 1'b0, 1'b0, 0);
    chk("csb_gap_ge20", (last_hi >= 20), 1'b1);

    frame16(16'($urandom), 16'($urandom), 1'b1, 1'b0, 0);
    frame16(16'($urandom), 16'($urandom), 1'b0, 1'b1, 0);
    repeat (4)
      frame16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
              1'b0, 0);

    frame16(16'($urandom), 16'($urandom), 1'b0, 1'b0, 8);
    frame16(16'($urandom), 16'($urandom), 1'b0, 1'b0, 0);

    sweep(1'b0, 32'h2);
    sweep(1'b0, 32'h1);
    sweep(1'b0, $urandom);
    sweep(1'b1, 32'h8000_0001);
    sweep(1'b1, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
